// File: rtl/reg_file_flags.sv
// Register file and architectural flags for the 8-bit ALU datapath.
// Two async read ports with write forwarding, one sync write port.
module reg_file_flags #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [W-1:0]  dat_a_o,
    output logic [W-1:0]  dat_b_o,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          flag_we,
    input  logic          sc_i,
    input  logic          zero_i,
    input  logic          pari_i,
    input  logic          carry_set,
    input  logic          carry_clr,
    output logic          carry_o,
    output logic          zero_o,
    output logic          pari_o
);

    localparam int NREG = 2 ** AW;

    logic [W-1:0] regs [NREG];
    logic         fwd_a;
    logic         fwd_b;
    logic         carry_q;
    logic         zero_q;
    logic         pari_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    // Bypass is suppressed during reset so the zeroed array is visible.
    always_comb begin
        fwd_a   = wr_en && reset_n && (wr_addr == rd_addr_a);
        fwd_b   = wr_en && reset_n && (wr_addr == rd_addr_b);
        dat_a_o = fwd_a ? wr_dat : regs[rd_addr_a];
        dat_b_o = fwd_b ? wr_dat : regs[rd_addr_b];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            pari_q  <= 1'b0;
        end else begin
            if (carry_clr) begin
                carry_q <= 1'b0;
            end else if (carry_set) begin
                carry_q <= 1'b1;
            end else if (flag_we) begin
                carry_q <= sc_i;
            end
            if (flag_we) begin
                zero_q <= zero_i;
                pari_q <= pari_i;
            end
        end
    end

    assign carry_o = carry_q;
    assign zero_o  = zero_q;
    assign pari_o  = pari_q;

endmodule

// File: tb/tb_reg_file_flags.sv
// Bench for reg_file_flags: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_reg_file_flags;

    logic       clk;
    logic       reset_n;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] dat_a_o;
    logic [7:0] dat_b_o;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_dat;
    logic       flag_we;
    logic       sc_i;
    logic       zero_i;
    logic       pari_i;
    logic       carry_set;
    logic       carry_clr;
    logic       carry_o;
    logic       zero_o;
    logic       pari_o;

    int n_chk;
    int n_fail;

    logic [7:0] mem [8];
    logic       m_c;
    logic       m_z;
    logic       m_p;

    reg_file_flags #(.W(8), .AW(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .dat_a_o   (dat_a_o),
        .dat_b_o   (dat_b_o),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_dat    (wr_dat),
        .flag_we   (flag_we),
        .sc_i      (sc_i),
        .zero_i    (zero_i),
        .pari_i    (pari_i),
        .carry_set (carry_set),
        .carry_clr (carry_clr),
        .carry_o   (carry_o),
        .zero_o    (zero_o),
        .pari_o    (pari_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        if (reset_n && wr_en && wr_addr == a) return wr_dat;
        return mem[a];
    endfunction

    task automatic idle();
        reset_n   = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_dat    = '0;
        flag_we   = 1'b0;
        sc_i      = 1'b0;
        zero_i    = 1'b0;
        pari_i    = 1'b0;
        carry_set = 1'b0;
        carry_clr = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
    endtask

    // Compare against the model mid-cycle, then advance one clock.
    task automatic step();
        @(negedge clk);
        chk("rd_a", {24'h0, dat_a_o}, {24'h0, exp_rd(rd_addr_a)});
        chk("rd_b", {24'h0, dat_b_o}, {24'h0, exp_rd(rd_addr_b)});
        chk("carry", {31'h0, carry_o}, {31'h0, m_c});
        chk("zero", {31'h0, zero_o}, {31'h0, m_z});
        chk("pari", {31'h0, pari_o}, {31'h0, m_p});
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
            m_c = 1'b0;
            m_z = 1'b0;
            m_p = 1'b0;
        end else begin
            if (wr_en) mem[wr_addr] = wr_dat;
            if (carry_clr) m_c = 1'b0;
            else if (carry_set) m_c = 1'b1;
            else if (flag_we) m_c = sc_i;
            if (flag_we) begin
                m_z = zero_i;
                m_p = pari_i;
            end
        end
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        m_c = 1'b0;
        m_z = 1'b0;
        m_p = 1'b0;
        idle();

        // Reset clears a written register and all flags
        wr_en = 1'b1; wr_addr = 3'd3; wr_dat = 8'hA5;
        flag_we = 1'b1; sc_i = 1'b1; zero_i = 1'b1; pari_i = 1'b1;
        step();
        idle();
        reset_n = 1'b0;
        step();
        idle();
        rd_addr_a = 3'd3;
        #1;
        chk("t1_r3", {24'h0, dat_a_o}, 32'h00);
        chk("t1_flags", {29'h0, carry_o, zero_o, pari_o}, 32'h0);
        step();

        // Write then read, with same-cycle forwarding
        wr_en = 1'b1; wr_addr = 3'd1; wr_dat = 8'h11;
        step();
        idle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_dat = 8'h3C; rd_addr_a = 3'd5;
        #1;
        chk("t2_fwd", {24'h0, dat_a_o}, 32'h3C);
        step();
        idle();
        rd_addr_a = 3'd5;
        #1;
        chk("t2_stored", {24'h0, dat_a_o}, 32'h3C);
        step();

        // Dual forward on both ports, then a stored read
        wr_en = 1'b1; wr_addr = 3'd2; wr_dat = 8'h81;
        rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        #1;
        chk("t3_fwd_a", {24'h0, dat_a_o}, 32'h81);
        chk("t3_fwd_b", {24'h0, dat_b_o}, 32'h81);
        rd_addr_a = 3'd1;
        #1;
        chk("t3_r1", {24'h0, dat_a_o}, 32'h11);
        step();

        // Flag capture and hold
        idle();
        flag_we = 1'b1; sc_i = 1'b1; zero_i = 1'b0; pari_i = 1'b1;
        step();
        idle();
        #1;
        chk("t4_cap", {29'h0, carry_o, zero_o, pari_o}, 32'b101);
        step();
        #1;
        chk("t4_hold", {29'h0, carry_o, zero_o, pari_o}, 32'b101);

        // Carry force priority
        carry_set = 1'b1; carry_clr = 1'b1; flag_we = 1'b1;
        sc_i = 1'b1; zero_i = 1'b1; pari_i = 1'b0;
        step();
        idle();
        #1;
        chk("t5_clr", {29'h0, carry_o, zero_o, pari_o}, 32'b010);
        carry_set = 1'b1; flag_we = 1'b1;
        sc_i = 1'b0; zero_i = 1'b0; pari_i = 1'b1;
        step();
        idle();
        #1;
        chk("t5_set", {29'h0, carry_o, zero_o, pari_o}, 32'b101);

        // Reset discards a concurrent write and blocks forwarding
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd7; wr_dat = 8'hFF; rd_addr_a = 3'd7;
        #1;
        chk("t6_nofwd", {24'h0, dat_a_o}, 32'h00);
        step();
        idle();
        rd_addr_a = 3'd7;
        #1;
        chk("t6_r7", {24'h0, dat_a_o}, 32'h00);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset_n   = ($urandom_range(0, 39) != 0);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_dat    = 8'($urandom);
            flag_we   = $urandom_range(0, 1);
            sc_i      = $urandom_range(0, 1);
            zero_i    = $urandom_range(0, 1);
            pari_i    = $urandom_range(0, 1);
            carry_set = ($urandom_range(0, 3) == 0);
            carry_clr = ($urandom_range(0, 3) == 0);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr
                                                    : 3'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
